// File: rtl/branch_resolve_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl_pkg
// Description : Shared types and constants for ID-stage branch resolution.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESOLVE = 2'd2
   } brState_e;

   localparam logic       BR_BEQ         = 1'b0;
   localparam logic       BR_BNE         = 1'b1;
   localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
   localparam int         MISS_CNT_W     = 16;

   // Two-bit saturating counter step toward the resolved direction.
   function automatic logic [1:0] ctrUpdate(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == 2'b11) ? ctr : ctr + 2'b01;
      end else begin
         return (ctr == 2'b00) ? ctr : ctr - 2'b01;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_ctrl_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_eval
// Description : Branch condition evaluation (beq / bne) on two operands.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
   import branch_resolve_ctrl_pkg::*;
(
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Op,
   output logic        Taken
);

   always_comb begin
      Taken = (Op == BR_BNE) ? (A != B) : (A == B);
   end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl
// Description : ID-stage branch resolution, mispredict flush and BTB update.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int MISS_W = MISS_CNT_W
)
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              BrValid,
   input  logic              BrOp,
   input  logic              OpReady,
   input  logic [31:0]       ReadA,
   input  logic [31:0]       ReadB,
   input  logic [31:0]       BrPC,
   input  logic [31:0]       BrTarget,
   input  logic              PredHit,
   input  logic              PredTaken,
   input  logic [1:0]        PredCtr,
   output logic              Stall,
   output logic              Flush,
   output logic [31:0]       RedirectPC,
   output logic              BtbWr,
   output logic [31:0]       BtbWrPC,
   output logic [31:0]       BtbWrTarget,
   output logic [1:0]        BtbWrCtr,
   output logic [MISS_W-1:0] MissCount
);

   brState_e          r_state;
   brState_e          w_nextState;
   logic              w_capture;

   logic              r_op;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [31:0]       r_pc;
   logic [31:0]       r_target;
   logic              r_predEff;
   logic              r_predHit;
   logic [1:0]        r_predCtr;
   logic [MISS_W-1:0] r_missCount;

   logic              w_taken;
   logic              w_resolve;
   logic              w_mispredict;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (BrValid) begin
               if (OpReady) begin
                  w_capture   = 1'b1;
                  w_nextState = RESOLVE;
               end else begin
                  w_nextState = WAIT;
               end
            end
         end
         WAIT: begin
            if (!BrValid) begin
               w_nextState = IDLE;
            end else if (OpReady) begin
               w_capture   = 1'b1;
               w_nextState = RESOLVE;
            end
         end
         RESOLVE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_comb begin
      Stall = ((r_state == IDLE) && BrValid) || (r_state == WAIT);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_op      <= BR_BEQ;
         r_a       <= '0;
         r_b       <= '0;
         r_pc      <= '0;
         r_target  <= '0;
         r_predEff <= 1'b0;
         r_predHit <= 1'b0;
         r_predCtr <= '0;
      end else if (w_capture) begin
         r_op      <= BrOp;
         r_a       <= ReadA;
         r_b       <= ReadB;
         r_pc      <= BrPC;
         r_target  <= BrTarget;
         r_predEff <= PredHit & PredTaken;
         r_predHit <= PredHit;
         r_predCtr <= PredCtr;
      end
   end

   branch_cond_eval u_condEval (
      .A     (r_a),
      .B     (r_b),
      .Op    (r_op),
      .Taken (w_taken)
   );

   // Everything below depends only on state and captured values, never on live inputs.
   always_comb begin
      w_resolve    = (r_state == RESOLVE);
      w_mispredict = w_resolve && (w_taken != r_predEff);
      Flush        = w_mispredict;
      RedirectPC   = '0;
      if (w_mispredict) begin
         RedirectPC = w_taken ? r_target : (r_pc + 32'd4);
      end
      BtbWr       = w_resolve && (r_predHit || w_taken);
      BtbWrPC     = r_pc;
      BtbWrTarget = r_target;
      if (r_predHit) begin
         BtbWrCtr = ctrUpdate(r_predCtr, w_taken);
      end else begin
         BtbWrCtr = w_taken ? CTR_WEAK_TAKEN : 2'b00;
      end
      MissCount = r_missCount;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_missCount <= '0;
      end else if (w_mispredict && (r_missCount != {MISS_W{1'b1}})) begin
         r_missCount <= r_missCount + MISS_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_ctrl
// Description : Directed vector bench for branch_resolve_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        BrValid;
   logic        BrOp;
   logic        OpReady;
   logic [31:0] ReadA;
   logic [31:0] ReadB;
   logic [31:0] BrPC;
   logic [31:0] BrTarget;
   logic        PredHit;
   logic        PredTaken;
   logic [1:0]  PredCtr;

   logic        Stall;
   logic        Flush;
   logic [31:0] RedirectPC;
   logic        BtbWr;
   logic [31:0] BtbWrPC;
   logic [31:0] BtbWrTarget;
   logic [1:0]  BtbWrCtr;
   logic [15:0] MissCount;

   logic        sStall;
   logic        sFlush;
   logic [31:0] sRedirectPC;
   logic        sBtbWr;
   logic [31:0] sBtbWrPC;
   logic [31:0] sBtbWrTarget;
   logic [1:0]  sBtbWrCtr;
   logic [3:0]  sMissCount;

   int checks   = 0;
   int failures = 0;
   int missBig  = 0;
   int missSmall = 0;

   always #5 Clk = ~Clk;

   branch_resolve_ctrl dut (
      .Clk(Clk), .Rst(Rst), .BrValid(BrValid), .BrOp(BrOp), .OpReady(OpReady),
      .ReadA(ReadA), .ReadB(ReadB), .BrPC(BrPC), .BrTarget(BrTarget),
      .PredHit(PredHit), .PredTaken(PredTaken), .PredCtr(PredCtr),
      .Stall(Stall), .Flush(Flush), .RedirectPC(RedirectPC), .BtbWr(BtbWr),
      .BtbWrPC(BtbWrPC), .BtbWrTarget(BtbWrTarget), .BtbWrCtr(BtbWrCtr),
      .MissCount(MissCount)
   );

   // Narrow miss counter copy so saturation is reachable in a short run.
   branch_resolve_ctrl #(.MISS_W(4)) dutSmall (
      .Clk(Clk), .Rst(Rst), .BrValid(BrValid), .BrOp(BrOp), .OpReady(OpReady),
      .ReadA(ReadA), .ReadB(ReadB), .BrPC(BrPC), .BrTarget(BrTarget),
      .PredHit(PredHit), .PredTaken(PredTaken), .PredCtr(PredCtr),
      .Stall(sStall), .Flush(sFlush), .RedirectPC(sRedirectPC), .BtbWr(sBtbWr),
      .BtbWrPC(sBtbWrPC), .BtbWrTarget(sBtbWrTarget), .BtbWrCtr(sBtbWrCtr),
      .MissCount(sMissCount)
   );

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        hit;
      logic        pTaken;
      logic [1:0]  ctr;
      int          waitCyc;
      logic        expFlush;
      logic [31:0] expRedir;
      logic        expBtbWr;
      logic [1:0]  expCtr;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      BrValid = 1'b0; BrOp = 1'b0; OpReady = 1'b0;
      ReadA = '0; ReadB = '0; BrPC = '0; BrTarget = '0;
      PredHit = 1'b0; PredTaken = 1'b0; PredCtr = '0;
   endtask

   task automatic chkMiss(input string tag);
      chk({tag, ".miss"}, 32'(MissCount), 32'(missBig));
      chk({tag, ".missSmall"}, 32'(sMissCount), 32'(missSmall));
   endtask

   // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
   task automatic runVec(input vec_t v, input string tag);
      for (int c = 0; c <= v.waitCyc; c++) begin
         BrValid = 1'b1; BrOp = v.op; BrPC = v.pc; BrTarget = v.tgt;
         PredHit = v.hit; PredTaken = v.pTaken; PredCtr = v.ctr;
         OpReady = (c == v.waitCyc);
         ReadA = v.a;
         // Operands seen before the ready cycle give the opposite outcome.
         ReadB = OpReady ? v.b : ((v.a == v.b) ? ~v.a : v.a);
         #1;
         chk({tag, ".stall"}, 32'(Stall), 32'd1);
         chk({tag, ".noFlushEarly"}, 32'(Flush), 32'd0);
         @(negedge Clk);
      end
      BrValid = 1'b0; OpReady = 1'b1; ReadA = 32'hDEAD; ReadB = 32'hBEEF;
      BrPC = 32'h1234_5678; BrTarget = 32'h8765_4321; BrOp = ~v.op;
      PredHit = ~v.hit; PredTaken = ~v.pTaken; PredCtr = ~v.ctr;
      #1;
      chk({tag, ".stallRes"}, 32'(Stall), 32'd0);
      chk({tag, ".flush"}, 32'(Flush), 32'(v.expFlush));
      chk({tag, ".redirect"}, RedirectPC, v.expRedir);
      chk({tag, ".btbWr"}, 32'(BtbWr), 32'(v.expBtbWr));
      if (v.expBtbWr) begin
         chk({tag, ".btbCtr"}, 32'(BtbWrCtr), 32'(v.expCtr));
         chk({tag, ".btbPC"}, BtbWrPC, v.pc);
         chk({tag, ".btbTgt"}, BtbWrTarget, v.tgt);
      end
      if (v.expFlush) begin
         missBig++;
         if (missSmall < 15) missSmall++;
      end
      @(negedge Clk);
      idleInputs();
      #1;
      chk({tag, ".flushIdle"}, 32'(Flush), 32'd0);
      chk({tag, ".btbWrIdle"}, 32'(BtbWr), 32'd0);
      chkMiss(tag);
   endtask

   initial begin
      //          op  a            b            pc            tgt           hit pT ctr wait flush redir         btbWr ctr
      vecs[0]  = '{1'b0, 32'h5,      32'h5,      32'h40,       32'h80,       1'b0, 1'b0, 2'd0, 0, 1'b1, 32'h80,       1'b1, 2'd2};
      vecs[1]  = '{1'b1, 32'h1,      32'h1,      32'h100,      32'h200,      1'b1, 1'b1, 2'd3, 0, 1'b1, 32'h104,      1'b1, 2'd2};
      vecs[2]  = '{1'b0, 32'h7,      32'h7,      32'h300,      32'h340,      1'b1, 1'b1, 2'd3, 0, 1'b0, 32'h0,        1'b1, 2'd3};
      vecs[3]  = '{1'b1, 32'h9,      32'h9,      32'h400,      32'h480,      1'b1, 1'b0, 2'd0, 0, 1'b0, 32'h0,        1'b1, 2'd0};
      vecs[4]  = '{1'b0, 32'h1234,   32'h1234,   32'h500,      32'h5F0,      1'b0, 1'b0, 2'd0, 3, 1'b1, 32'h5F0,      1'b1, 2'd2};
      vecs[5]  = '{1'b0, 32'h1,      32'h2,      32'hFFFFFFFC, 32'h10,       1'b1, 1'b1, 2'd2, 0, 1'b1, 32'h0,        1'b1, 2'd1};
      vecs[6]  = '{1'b1, 32'h3,      32'h4,      32'h600,      32'h700,      1'b0, 1'b0, 2'd0, 0, 1'b1, 32'h700,      1'b1, 2'd2};
      vecs[7]  = '{1'b0, 32'h3,      32'h4,      32'h610,      32'h710,      1'b0, 1'b0, 2'd0, 0, 1'b0, 32'h0,        1'b0, 2'd0};
      vecs[8]  = '{1'b1, 32'h3,      32'h4,      32'h620,      32'h720,      1'b1, 1'b1, 2'd1, 1, 1'b0, 32'h0,        1'b1, 2'd2};
      vecs[9]  = '{1'b0, 32'h5,      32'h6,      32'h630,      32'h730,      1'b0, 1'b1, 2'd3, 0, 1'b0, 32'h0,        1'b0, 2'd0};
      vecs[10] = '{1'b0, 32'h5,      32'h5,      32'h640,      32'h740,      1'b1, 1'b0, 2'd1, 0, 1'b1, 32'h740,      1'b1, 2'd2};

      Rst = 1'b1;
      idleInputs();
      repeat (2) @(negedge Clk);
      #1;
      chk("rst.flush", 32'(Flush), 32'd0);
      chk("rst.btbWr", 32'(BtbWr), 32'd0);
      chk("rst.redirect", RedirectPC, 32'd0);
      chk("rst.stall", 32'(Stall), 32'd0);
      chkMiss("rst");
      Rst = 1'b0;
      @(negedge Clk);

      for (int i = 0; i < 11; i++) begin
         runVec(vecs[i], $sformatf("v%0d", i));
      end

      // Branch squashed while waiting for operands.
      BrValid = 1'b1; OpReady = 1'b0; ReadA = 32'h1; ReadB = 32'h1;
      #1 chk("sq.stallIdle", 32'(Stall), 32'd1);
      @(negedge Clk);
      BrValid = 1'b0;
      #1 chk("sq.stallWait", 32'(Stall), 32'd1);
      @(negedge Clk);
      OpReady = 1'b1;
      #1;
      chk("sq.stallAfter", 32'(Stall), 32'd0);
      chk("sq.flush", 32'(Flush), 32'd0);
      chk("sq.btbWr", 32'(BtbWr), 32'd0);
      @(negedge Clk);
      #1;
      chk("sq.flush2", 32'(Flush), 32'd0);
      chk("sq.btbWr2", 32'(BtbWr), 32'd0);
      chkMiss("sq");
      idleInputs();

      // Reset while in WAIT, with OpReady rising on the same edge.
      BrValid = 1'b1; OpReady = 1'b0; ReadA = 32'h5; ReadB = 32'h5;
      @(negedge Clk);
      Rst = 1'b1; OpReady = 1'b1;
      @(negedge Clk);
      Rst = 1'b0; BrValid = 1'b0;
      missBig = 0; missSmall = 0;
      #1;
      chk("rstWait.stall", 32'(Stall), 32'd0);
      chk("rstWait.btbWr", 32'(BtbWr), 32'd0);
      chk("rstWait.flush", 32'(Flush), 32'd0);
      chkMiss("rstWait");
      @(negedge Clk);
      idleInputs();

      runVec(vecs[0], "preRst");

      // Reset asserted during a mispredicting RESOLVE.
      BrValid = 1'b1; OpReady = 1'b1; ReadA = 32'h5; ReadB = 32'h5;
      BrPC = 32'h40; BrTarget = 32'h80;
      @(negedge Clk);
      idleInputs();
      Rst = 1'b1;
      @(negedge Clk);
      missBig = 0; missSmall = 0;
      #1;
      chk("rstRes.flush", 32'(Flush), 32'd0);
      chk("rstRes.btbWr", 32'(BtbWr), 32'd0);
      chk("rstRes.redirect", RedirectPC, 32'd0);
      chk("rstRes.stall", 32'(Stall), 32'd0);
      chkMiss("rstRes");
      Rst = 1'b0;
      @(negedge Clk);
      #1 chkMiss("rstRes2");

      // Drive the narrow counter into saturation and beyond.
      for (int i = 0; i < 17; i++) begin
         runVec(vecs[6], $sformatf("sat%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named Clk and Rst.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  synchronous active-high reset.
REQ-004 BrValid  input  1  branch instruction present in ID.
REQ-005 BrOp  input  1  branch type: 0=beq, 1=bne.
REQ-006 OpReady  input  1  ReadA/ReadB valid (forwarding resolved).
REQ-007 ReadA, ReadB  input  32 each  branch source operands.
REQ-008 BrPC  input  32  branch instruction PC.
REQ-009 BrTarget  input  32  computed branch target.
REQ-010 PredHit  input  1  BTB hit for BrPC.
REQ-011 PredTaken  input  1  BTB prediction; ignored when PredHit=0.
REQ-012 PredCtr  input  2  BTB 2-bit counter for BrPC.
REQ-013 Stall  output  1  hold IF/ID.
REQ-014 Flush  output  1  squash wrong-path IF/ID, one-cycle pulse.
REQ-015 RedirectPC  output  32  corrected fetch PC, valid when Flush=1.
REQ-016 BtbWr, BtbWrPC[32], BtbWrTarget[32], BtbWrCtr[2]  output  BTB update port, BtbWr is a one-cycle pulse.
REQ-017 MissCount  output  16  mispredict counter.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT, and RESOLVE.
REQ-019 IDLE transitions:
- BrValid=1, OpReady=0: go to WAIT.
- BrValid=1, OpReady=1: capture BrOp, ReadA, ReadB, BrPC, BrTarget, the effective prediction (PredHit&PredTaken), PredHit and PredCtr, then go to RESOLVE.
REQ-020 WAIT transitions:
- BrValid=0: return to IDLE with no Flush and no BtbWr (branch squashed).
- OpReady=1: perform the REQ-019 capture and go to RESOLVE.
- Otherwise: stay in WAIT.
REQ-021 Stall SHALL be the combinational value (IDLE&BrValid) | WAIT, and SHALL be 0 in RESOLVE; each branch therefore costs a minimum of one stall cycle.
REQ-022 In RESOLVE, the actual outcome SHALL be taken = (A==B) for beq and taken = (A!=B) for bne, computed on the captured operands.
REQ-023 Flush SHALL be 1 in RESOLVE iff taken differs from the effective prediction.
REQ-024 On mispredict, RedirectPC SHALL be:
- BrTarget if taken=1.
- BrPC+4 (mod 2^32) if taken=0.
REQ-025 RedirectPC SHALL be 0 whenever Flush=0.
REQ-026 BTB update in RESOLVE:
- PredHit=1: BtbWr=1, and BtbWrCtr = PredCtr saturating-incremented if taken, saturating-decremented if not taken (3 stays 3, 0 stays 0).
- PredHit=0 and taken=1: BtbWr=1 with BtbWrCtr=2'b10.
- PredHit=0 and taken=0: BtbWr=0.
- BtbWrPC = captured BrPC; BtbWrTarget = captured BrTarget.
REQ-027 MissCount SHALL increment on every Flush and saturate at 16'hFFFF.
REQ-028 RESOLVE SHALL always return to IDLE the next cycle; a following branch is accepted from IDLE, with no overlap.
REQ-029 All outputs other than Stall SHALL be registered or decoded only from state and captured values, so no input-to-output combinational path exists except into Stall.

Reset
REQ-030 On Rst=1 at a clock edge, the state SHALL be IDLE, all captured registers 0, and MissCount 0.
REQ-031 While in reset, Flush, BtbWr and RedirectPC SHALL read 0, and Rst SHALL take priority over all transitions, including mid-WAIT and mid-RESOLVE.
REQ-032 A reset asserted in RESOLVE SHALL suppress that cycle's Flush and BtbWr at the next edge onward, and SHALL NOT increment MissCount.

Structure
REQ-033 A shared package SHALL hold:
- State encodings: IDLE=2'd0, WAIT=2'd1, RESOLVE=2'd2.
- BR_BEQ=1'b0 and BR_BNE=1'b1.
- CTR_WEAK_TAKEN=2'b10.
- MISS_CNT_W=16.
REQ-034 The equality/inequality condition SHALL be a sub-module branch_cond_eval (inputs A, B, Op; output Taken), instantiated once on the captured operands.

Verification
REQ-035 beq, A=B=32'h5, PredHit=0, OpReady=1 -> Stall for 1 cycle; RESOLVE gives Flush=1, RedirectPC=BrTarget, BtbWr=1, BtbWrCtr=2'b10, MissCount=1.
REQ-036 bne, A=1, B=1, PredHit=1, PredTaken=1, PredCtr=3, BrPC=32'h100 -> Flush=1, RedirectPC=32'h104, BtbWrCtr=2'b10.
REQ-037 beq, A=B, PredHit=1, PredTaken=1, PredCtr=3 -> Flush=0, BtbWr=1, BtbWrCtr=3 (saturated); bne, A=B, PredHit=1, PredCtr=0 -> Flush=0, BtbWrCtr=0.
REQ-038 OpReady=0 for 3 cycles, then 1 -> Stall high for 4 cycles and the outcome is taken from the operands present on the ready cycle; a second run with BrValid dropped in WAIT -> IDLE with no Flush and no BtbWr.
REQ-039 BrPC=32'hFFFFFFFC, predicted taken, actually not taken -> RedirectPC=32'h0; MissCount preset via 65535 mispredicts stays 16'hFFFF after one more.
REQ-040 Rst asserted while in WAIT and again during RESOLVE -> next cycle IDLE, Stall=0, no BtbWr, MissCount=0.
